// File: rtl/fifo_pkg.sv
// Shared constants, types and vector-side FSM states for the vector FIFO.
package fifo_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned DEPTH_DEF  = 16;
    localparam int unsigned AW_DEF     = $clog2(DEPTH_DEF);
    localparam int unsigned CNT_W_DEF  = AW_DEF + 1;

    typedef logic [DATA_W_DEF-1:0] data_t;
    typedef logic [CNT_W_DEF-1:0]  ptr_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FILL  = 2'b01,
        ST_READY = 2'b10
    } vec_state_e;

endpackage

// File: rtl/ram_dp_sync.sv
// Single-clock dual-port RAM: synchronous write, registered read with clearable output.
module ram_dp_sync #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage array; contents are not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register holds its value between reads; old data wins on same-address write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (clr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_vector_gen.sv
// Vector FIFO: circular buffer with vector-length tracking, status and sticky error flags.
module fifo_vector_gen #(
    parameter int unsigned DATA_W = fifo_pkg::DATA_W_DEF,
    parameter int unsigned DEPTH  = fifo_pkg::DEPTH_DEF,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CNT_W-1:0]  len,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              last_out,
    output logic              ready,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    import fifo_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);

    vec_state_e       state_q, state_d;
    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] vec_idx_q, vec_idx_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] len_legal;
    logic             full_d, empty_d, ovf_d, unf_d, valid_d, last_d;
    logic             push_acc, pop_acc;

    // Element storage; writes/reads suppressed during flush.
    ram_dp_sync #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .we    (push_acc & ~clr),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (data_in),
        .re    (pop_acc & ~clr),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (data_out)
    );

    // Next-state: pointers, occupancy, vector tracking, flags and FSM.
    always_comb begin
        pop_acc   = pop & ~empty;
        push_acc  = push & (~full | pop_acc);
        len_legal = (len == '0 || len > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : len;

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count;
        vec_idx_d = vec_idx_q;
        len_d     = len_q;
        full_d    = full;
        empty_d   = empty;
        ovf_d     = overflow;
        unf_d     = underflow;
        valid_d   = 1'b0;
        last_d    = 1'b0;
        state_d   = state_q;

        if (clr) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            vec_idx_d = '0;
            len_d     = CNT_W'(DEPTH);
            full_d    = 1'b0;
            empty_d   = 1'b1;
            ovf_d     = 1'b0;
            unf_d     = 1'b0;
            state_d   = ST_EMPTY;
        end else begin
            wr_ptr_d = wr_ptr_q + CNT_W'(push_acc);
            rd_ptr_d = rd_ptr_q + CNT_W'(pop_acc);
            count_d  = count + CNT_W'(push_acc) - CNT_W'(pop_acc);
            ovf_d    = overflow | (push & ~push_acc);
            unf_d    = underflow | (pop & ~pop_acc);

            // Length only changes while idle and empty, so an in-flight vector keeps its size.
            if (empty && !push_acc) begin
                len_d = len_legal;
            end

            if (pop_acc) begin
                valid_d = 1'b1;
                if (vec_idx_q == len_q - CNT_W'(1)) begin
                    last_d    = 1'b1;
                    vec_idx_d = '0;
                end else begin
                    vec_idx_d = vec_idx_q + CNT_W'(1);
                end
            end

            full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                      (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
            empty_d = (wr_ptr_d == rd_ptr_d);

            if (count_d == '0) begin
                state_d = ST_EMPTY;
            end else if (count_d < len_d) begin
                state_d = ST_FILL;
            end else begin
                state_d = ST_READY;
            end
        end
    end

    // State register for all control and status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_EMPTY;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            vec_idx_q <= '0;
            len_q     <= CNT_W'(DEPTH);
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            vec_idx_q <= vec_idx_d;
            len_q     <= len_d;
            count     <= count_d;
            full      <= full_d;
            empty     <= empty_d;
            overflow  <= ovf_d;
            underflow <= unf_d;
            valid_out <= valid_d;
            last_out  <= last_d;
        end
    end

    // A full vector is buffered exactly when the FSM sits in READY.
    assign ready = (state_q == ST_READY);

endmodule

// File: tb/tb_fifo_vector_gen.sv
// Scoreboard bench for fifo_vector_gen: directed scenarios plus a random phase.
module tb_fifo_vector_gen;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned CNT_W  = 5;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } sb_t;

    logic              clk = 1'b0;
    logic              rst, clr, push, pop;
    logic [DATA_W-1:0] data_in;
    logic [CNT_W-1:0]  len;
    logic [DATA_W-1:0] data_out;
    logic              valid_out, last_out, ready, full, empty, overflow, underflow;
    logic [CNT_W-1:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] mq[$];
    sb_t               sb_q[$];
    int                m_len, m_vidx;
    logic              m_ovf, m_unf;

    always #5 clk = ~clk;

    fifo_vector_gen #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .push      (push),
        .pop       (pop),
        .data_in   (data_in),
        .len       (len),
        .data_out  (data_out),
        .valid_out (valid_out),
        .last_out  (last_out),
        .ready     (ready),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        sb_q.delete();
        m_len  = DEPTH;
        m_vidx = 0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check({tag, "/count"},     32'(count),     32'(mq.size()));
        check({tag, "/full"},      32'(full),      32'(mq.size() == DEPTH));
        check({tag, "/empty"},     32'(empty),     32'(mq.size() == 0));
        check({tag, "/ready"},     32'(ready),     32'(mq.size() >= m_len));
        check({tag, "/overflow"},  32'(overflow),  32'(m_ovf));
        check({tag, "/underflow"}, 32'(underflow), 32'(m_unf));
    endtask

    // One clock of stimulus; model advances on the edge, outputs checked 1ns later.
    task automatic step(input logic p, input logic q, input logic [DATA_W-1:0] d, input logic c);
        logic pop_ok, push_ok, full_m, empty_m;
        sb_t  e;
        push    = p;
        pop     = q;
        data_in = d;
        clr     = c;
        @(posedge clk);
        pop_ok = 1'b0;
        if (c) begin
            model_reset();
        end else begin
            empty_m = (mq.size() == 0);
            full_m  = (mq.size() == DEPTH);
            pop_ok  = q && !empty_m;
            push_ok = p && (!full_m || pop_ok);
            if (empty_m && !push_ok)
                m_len = (len == 0 || len > CNT_W'(DEPTH)) ? DEPTH : int'(len);
            if (p && !push_ok) m_ovf = 1'b1;
            if (q && !pop_ok)  m_unf = 1'b1;
            if (pop_ok) begin
                e.data = mq.pop_front();
                e.last = (m_vidx == m_len - 1);
                m_vidx = e.last ? 0 : m_vidx + 1;
                sb_q.push_back(e);
            end
            if (push_ok) mq.push_back(d);
        end
        #1;
        check("valid_out", 32'(valid_out), 32'(pop_ok));
        if (valid_out && sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("data_out", data_out, e.data);
            check("last_out", 32'(last_out), 32'(e.last));
        end
        check_status("st");
    endtask

    task automatic async_reset();
        push = 1'b0;
        pop  = 1'b0;
        clr  = 1'b0;
        #1 rst = 1'b0;
        #2;
        check("arst/count", 32'(count), 32'd0);
        check("arst/empty", 32'(empty), 32'd1);
        check("arst/valid", 32'(valid_out), 32'd0);
        check("arst/data",  data_out, 32'd0);
        model_reset();
        #2 rst = 1'b1;
    endtask

    initial begin
        logic [DATA_W-1:0] held;
        rst = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0; len = 5'd4;
        model_reset();
        #12 rst = 1'b1;
        #1;
        check("reset/data_out", data_out, 32'd0);
        check("reset/valid",    32'(valid_out), 32'd0);
        check_status("reset");

        // Basic vector of four.
        step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 32'hA0 + 32'(i), 0);
        check("vec4/ready", 32'(ready), 32'd1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
        held = data_out;
        step(0, 0, 0, 0);
        check("hold/data_out", data_out, 32'hA3);
        check("hold/same", data_out, held);

        // Fill past capacity, then drain one too many.
        len = 5'd16;
        step(0, 0, 0, 0);
        for (int i = 0; i < 17; i++) step(1, 0, 32'(i), 0);
        for (int i = 0; i < 17; i++) step(0, 1, 0, 0);
        step(0, 0, 0, 1);

        // Pointer wrap-around.
        len = 5'd4;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 10; i++) step(1, 0, 32'h100 * 32'(r + 1) + 32'(i), 0);
            for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
        end
        for (int i = 0; i < 16; i++) step(1, 0, 32'h300 + 32'(i), 0);
        check("wrap/full", 32'(full), 32'd1);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0);

        // Simultaneous push and pop at full and at empty.
        for (int i = 0; i < 16; i++) step(1, 0, 32'h400 + 32'(i), 0);
        step(1, 1, 32'h4FF, 0);
        check("fullpp/count", 32'(count), 32'd16);
        check("fullpp/ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0);
        step(1, 1, 32'h500, 0);
        check("emptypp/count", 32'(count), 32'd1);
        check("emptypp/unf", 32'(underflow), 32'd1);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);

        // Length change while a vector is in flight.
        len = 5'd4;
        step(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) step(1, 0, 32'h600 + 32'(i), 0);
        len = 5'd3;
        for (int i = 2; i < 4; i++) step(1, 0, 32'h600 + 32'(i), 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 32'h700 + 32'(i), 0);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0);

        // Flush with a concurrent pop.
        for (int i = 0; i < 7; i++) step(1, 0, 32'h800 + 32'(i), 0);
        step(0, 1, 0, 1);
        check("clr/data_out", data_out, 32'd0);

        // Random traffic with an asynchronous reset in the middle.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) async_reset();
            if ($urandom_range(0, 9) == 0) len = 5'($urandom_range(0, 20));
            step(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 5),
                 $urandom(), 1'($urandom_range(0, 49) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_vector_gen.md
# fifo_vector_gen

Parametrised vector FIFO, the next-generation replacement for the fixed-width vector buffer between the vector loader and the processing datapath. Stores DATA_W-bit elements in a DEPTH-entry circular buffer, signals `ready` once a complete vector of programmable length `len` is buffered, and tags the last element of each vector on the read side. It adds full/empty/level status, sticky overflow/underflow flags, a synchronous flush and registered read data with an explicit valid.

## Interface
- DATA_W, 32, element width in bits
- DEPTH, 16, number of entries; power of two, ≥ 2
- CNT_W, $clog2(DEPTH)+1, width of `len` and `count`
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous active-low reset
- clr  in  1  synchronous flush: empties FIFO, clears flags and vector tracking
- push  in  1  write request for `data_in`
- pop  in  1  read request
- data_in  in  DATA_W  element to store
- len  in  CNT_W  vector length N; legal 1..DEPTH
- data_out  out  DATA_W  registered read data
- valid_out  out  1  `data_out` holds an element popped the previous cycle
- last_out  out  1  qualifies `valid_out`: element is the final element of its vector
- ready  out  1  at least one full vector (`count` ≥ len_q) buffered
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  CNT_W  current occupancy
- overflow  out  1  sticky: push refused while full
- underflow  out  1  sticky: pop refused while empty

## Operation
- Reset (rst=0) or clr=1: wr_ptr, rd_ptr, count, vec_idx = 0; len_q = DEPTH; data_out = 0; valid_out, last_out, ready, full, overflow, underflow = 0; empty = 1. clr takes priority over push/pop in the same cycle.
- Pointers are CNT_W bits; the low $clog2(DEPTH) bits address RAM. Wrap DEPTH-1 → 0 is natural; full = MSBs differ and low bits equal.
- Length latch: len_q ← len on any cycle where empty=1 and no push is accepted. Otherwise held, so a vector in flight never changes length. len = 0 or > DEPTH latches DEPTH.
- Accepted push = push & (!full | pop_acc). Accepted pop = pop & !empty. Full + push + pop: both accepted, count unchanged. Empty + push + pop: push accepted, pop refused, underflow set.
- Refused push sets overflow; refused pop sets underflow; both held until clr or reset.
- count += push_acc − pop_acc. ready = (count ≥ len_q), from registered count.
- vec_idx counts accepted pops modulo len_q; last_out = 1 when the popped element had vec_idx == len_q−1, after which vec_idx → 0.
- FSM (vector side), states: EMPTY (count=0), FILL (0 < count < len_q), READY (count ≥ len_q). Transitions follow the next count value; `ready` is high exactly in READY. The FSM is informational only: push/pop are never gated by state.

## Timing
- Write: data visible to the read port the cycle after push_acc. Push-then-pop on consecutive cycles is legal.
- Read latency 1: pop_acc at edge k → data_out, valid_out, last_out valid after edge k+1. valid_out is a one-cycle pulse per accepted pop. data_out holds its value when there is no pop.
- Status outputs (full, empty, count, ready) update on the edge that accepts the operation.
- Asynchronous reset mid-operation clears everything immediately. Stored RAM contents are don't-care.

## Structure
- Shared fifo_pkg: parametrised data/pointer typedefs, DEPTH/width constants, FSM state enum (ST_EMPTY, ST_FILL, ST_READY).
- Sub-module `ram_dp_sync`: single-clock dual-port RAM, synchronous write, registered read, parametrised DATA_W/DEPTH.
- Pointers, count, flags, vec_idx and FSM live in the top module.

## Test plan
- Reset then len=4: push 0xA0..0xA3 → ready rises with count=4 after 4th push; pop ×4 → data_out A0..A3 one cycle after each pop, last_out only with A3, empty=1.
- DEPTH=16: push 17 elements → full=1 after 16th, 17th refused, overflow=1, count=16; pop all → element order 0..15 intact.
- Wrap-around: push 10/pop 10 twice, then push 16 → full=1 with pointer wrap, readback in order.
- Full with simultaneous push+pop → count stays 16, no overflow; empty with push+pop → count=1, underflow=1.
- Change len 4→3 mid-vector (count=2) → len_q stays 4; after drain to empty, new len=3 latched and last_out every 3rd pop.
- clr at count=7 with pop asserted → next cycle empty=1, count=0, flags 0, valid_out=0.
